sram_arbiter: RTL and testbench

// Shares one sram_controller between two requester ports (m0, m1) with round-robin

---
 rtl/sram_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one sram_controller between two requester ports.
// Per-type ID FIFOs route write_done / read_data_valid back to the issuing port.
module sram_arbiter #(
    parameter int unsigned ADDR_BITS     = 10,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned PENDING_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 m0_req,
    output logic                 m0_ready,
    input  logic                 m0_write_enable,
    input  logic [ADDR_BITS-1:0] m0_addr,
    input  logic [DATA_BITS-1:0] m0_write_data,
    output logic                 m0_write_done,
    output logic [DATA_BITS-1:0] m0_read_data,
    output logic                 m0_read_data_valid,

    input  logic                 m1_req,
    output logic                 m1_ready,
    input  logic                 m1_write_enable,
    input  logic [ADDR_BITS-1:0] m1_addr,
    input  logic [DATA_BITS-1:0] m1_write_data,
    output logic                 m1_write_done,
    output logic [DATA_BITS-1:0] m1_read_data,
    output logic                 m1_read_data_valid,

    output logic                 ctrl_req,
    input  logic                 ctrl_ready,
    output logic                 ctrl_write_enable,
    output logic [ADDR_BITS-1:0] ctrl_addr,
    output logic [DATA_BITS-1:0] ctrl_write_data,
    input  logic                 ctrl_write_done,
    input  logic [DATA_BITS-1:0] ctrl_read_data,
    input  logic                 ctrl_read_data_valid
);

    localparam int unsigned PTR_W    = $clog2(PENDING_DEPTH);
    localparam int unsigned PTR_BITS = PTR_W + 1;

    logic                     r_prio;    // 0 = m0 preferred on a tie
    logic [PENDING_DEPTH-1:0] r_rd_ids;
    logic [PENDING_DEPTH-1:0] r_wr_ids;
    logic [PTR_BITS-1:0]      r_rd_wptr;
    logic [PTR_BITS-1:0]      r_rd_rptr;
    logic [PTR_BITS-1:0]      r_wr_wptr;
    logic [PTR_BITS-1:0]      r_wr_rptr;

    logic w_rd_full;
    logic w_rd_empty;
    logic w_wr_full;
    logic w_wr_empty;
    logic w_elig0;
    logic w_elig1;
    logic w_grant;
    logic w_issue;
    logic w_rd_push;
    logic w_wr_push;
    logic w_rd_pop;
    logic w_wr_pop;
    logic w_rd_head;
    logic w_wr_head;

    // Full when the wrap bits differ and the index bits match.
    assign w_rd_full  = (r_rd_wptr[PTR_W] != r_rd_rptr[PTR_W]) &&
                        (r_rd_wptr[PTR_W-1:0] == r_rd_rptr[PTR_W-1:0]);
    assign w_wr_full  = (r_wr_wptr[PTR_W] != r_wr_rptr[PTR_W]) &&
                        (r_wr_wptr[PTR_W-1:0] == r_wr_rptr[PTR_W-1:0]);
    assign w_rd_empty = (r_rd_wptr == r_rd_rptr);
    assign w_wr_empty = (r_wr_wptr == r_wr_rptr);

    assign w_elig0 = m0_req & (m0_write_enable ? !w_wr_full : !w_rd_full);
    assign w_elig1 = m1_req & (m1_write_enable ? !w_wr_full : !w_rd_full);

    // Winner: 1 selects m1. With nobody eligible this falls back to m0.
    assign w_grant = (w_elig0 & w_elig1) ? r_prio : w_elig1;

    assign ctrl_req          = w_elig0 | w_elig1;
    assign ctrl_write_enable = w_grant ? m1_write_enable : m0_write_enable;
    assign ctrl_addr         = w_grant ? m1_addr         : m0_addr;
    assign ctrl_write_data   = w_grant ? m1_write_data   : m0_write_data;

    assign w_issue  = ctrl_req & ctrl_ready;
    assign m0_ready = w_issue & !w_grant;
    assign m1_ready = w_issue &  w_grant;

    assign w_rd_push = w_issue & !ctrl_write_enable;
    assign w_wr_push = w_issue &  ctrl_write_enable;
    assign w_rd_pop  = ctrl_read_data_valid & !w_rd_empty;
    assign w_wr_pop  = ctrl_write_done      & !w_wr_empty;
    assign w_rd_head = r_rd_ids[r_rd_rptr[PTR_W-1:0]];
    assign w_wr_head = r_wr_ids[r_wr_rptr[PTR_W-1:0]];

    // Priority and ID FIFO state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio    <= 1'b0;
            r_rd_ids  <= '0;
            r_wr_ids  <= '0;
            r_rd_wptr <= '0;
            r_rd_rptr <= '0;
            r_wr_wptr <= '0;
            r_wr_rptr <= '0;
        end else begin
            if (w_issue) begin
                r_prio <= ~w_grant;
            end
            if (w_rd_push) begin
                r_rd_ids[r_rd_wptr[PTR_W-1:0]] <= w_grant;
                r_rd_wptr <= r_rd_wptr + PTR_BITS'(1);
            end
            if (w_wr_push) begin
                r_wr_ids[r_wr_wptr[PTR_W-1:0]] <= w_grant;
                r_wr_wptr <= r_wr_wptr + PTR_BITS'(1);
            end
            if (w_rd_pop) begin
                r_rd_rptr <= r_rd_rptr + PTR_BITS'(1);
            end
            if (w_wr_pop) begin
                r_wr_rptr <= r_wr_rptr + PTR_BITS'(1);
            end
        end
    end

    // Registered return path; read data is broadcast to both ports.
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_read_data_valid <= 1'b0;
            m1_read_data_valid <= 1'b0;
            m0_write_done      <= 1'b0;
            m1_write_done      <= 1'b0;
            m0_read_data       <= '0;
            m1_read_data       <= '0;
        end else begin
            m0_read_data_valid <= w_rd_pop & !w_rd_head;
            m1_read_data_valid <= w_rd_pop &  w_rd_head;
            m0_write_done      <= w_wr_pop & !w_wr_head;
            m1_write_done      <= w_wr_pop &  w_wr_head;
            if (ctrl_read_data_valid) begin
                m0_read_data <= ctrl_read_data;
                m1_read_data <= ctrl_read_data;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: behavioural sram_controller, reference
// arbiter model with completion scoreboard, grant vector table and corner sequences.
module tb_sram_arbiter;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int          NV    = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_ready, m0_write_enable, m0_write_done, m0_read_data_valid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_write_data, m0_read_data;
    logic          m1_req, m1_ready, m1_write_enable, m1_write_done, m1_read_data_valid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_write_data, m1_read_data;
    logic          ctrl_req, ctrl_ready, ctrl_write_enable, ctrl_write_done, ctrl_read_data_valid;
    logic [AW-1:0] ctrl_addr;
    logic [DW-1:0] ctrl_write_data, ctrl_read_data;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .PENDING_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_ready(m0_ready), .m0_write_enable(m0_write_enable),
        .m0_addr(m0_addr), .m0_write_data(m0_write_data), .m0_write_done(m0_write_done),
        .m0_read_data(m0_read_data), .m0_read_data_valid(m0_read_data_valid),
        .m1_req(m1_req), .m1_ready(m1_ready), .m1_write_enable(m1_write_enable),
        .m1_addr(m1_addr), .m1_write_data(m1_write_data), .m1_write_done(m1_write_done),
        .m1_read_data(m1_read_data), .m1_read_data_valid(m1_read_data_valid),
        .ctrl_req(ctrl_req), .ctrl_ready(ctrl_ready), .ctrl_write_enable(ctrl_write_enable),
        .ctrl_addr(ctrl_addr), .ctrl_write_data(ctrl_write_data),
        .ctrl_write_done(ctrl_write_done), .ctrl_read_data(ctrl_read_data),
        .ctrl_read_data_valid(ctrl_read_data_valid)
    );

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic          r0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          x0, x1;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t          exp_rd_q[$];
    exp_t          exp_wr_q[$];
    logic [DW-1:0] c_rd_q[$];
    int            c_wr_cnt = 0;
    logic [DW-1:0] mem [1024];
    logic          hold_rd = 1'b0, hold_wr = 1'b0, stray_rd = 1'b0;

    logic          prio_m = 1'b0;
    logic          pr_v = 1'b0, pr_p = 1'b0, pw_v = 1'b0, pw_p = 1'b0;
    logic [DW-1:0] pr_d = '0;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and drive the controller's completion lines for it.
    task automatic tick();
        @(posedge clk);
        #1;
        ctrl_read_data_valid = 1'b0;
        ctrl_write_done      = 1'b0;
        if (!hold_rd && c_rd_q.size() > 0) begin
            ctrl_read_data_valid = 1'b1;
            ctrl_read_data       = c_rd_q.pop_front();
        end else if (stray_rd) begin
            ctrl_read_data_valid = 1'b1;
            ctrl_read_data       = 8'hEE;
        end
        if (!hold_wr && c_wr_cnt > 0) begin
            ctrl_write_done = 1'b1;
            c_wr_cnt--;
        end
    endtask

    task automatic set_m0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m0_req = r; m0_write_enable = w; m0_addr = a; m0_write_data = d;
    endtask

    task automatic set_m1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m1_req = r; m1_write_enable = w; m1_addr = a; m1_write_data = d;
    endtask

    task automatic idle();
        set_m0(1'b0, 1'b0, '0, '0);
        set_m1(1'b0, 1'b0, '0, '0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_m0_wdone"}, 32'(m0_write_done), 32'(0));
        chk({tag, "_m1_wdone"}, 32'(m1_write_done), 32'(0));
        chk({tag, "_m0_rvalid"}, 32'(m0_read_data_valid), 32'(0));
        chk({tag, "_m1_rvalid"}, 32'(m1_read_data_valid), 32'(0));
        chk({tag, "_m0_rdata"}, 32'(m0_read_data), 32'(0));
        chk({tag, "_m1_rdata"}, 32'(m1_read_data), 32'(0));
    endtask

    // Reference model, scoreboard and controller capture, sampled mid-cycle.
    always @(negedge clk) begin : mon
        logic e0, e1, win, iss, wwe;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        exp_t it;
        e0 = m0_req & (m0_write_enable ? (exp_wr_q.size() < int'(DEPTH)) : (exp_rd_q.size() < int'(DEPTH)));
        e1 = m1_req & (m1_write_enable ? (exp_wr_q.size() < int'(DEPTH)) : (exp_rd_q.size() < int'(DEPTH)));
        win   = (e0 & e1) ? prio_m : e1;
        iss   = (e0 | e1) & ctrl_ready;
        wwe   = win ? m1_write_enable : m0_write_enable;
        waddr = win ? m1_addr : m0_addr;
        wdata = win ? m1_write_data : m0_write_data;
        if (!reset) begin
            chk("m0_rvalid", 32'(m0_read_data_valid), 32'(pr_v && !pr_p));
            chk("m1_rvalid", 32'(m1_read_data_valid), 32'(pr_v && pr_p));
            if (pr_v) begin
                chk("m0_rdata", 32'(m0_read_data), 32'(pr_d));
                chk("m1_rdata", 32'(m1_read_data), 32'(pr_d));
            end
            chk("m0_wdone", 32'(m0_write_done), 32'(pw_v && !pw_p));
            chk("m1_wdone", 32'(m1_write_done), 32'(pw_v && pw_p));
            chk("ctrl_req", 32'(ctrl_req), 32'(e0 | e1));
            chk("m0_ready", 32'(m0_ready), 32'(iss && !win));
            chk("m1_ready", 32'(m1_ready), 32'(iss && win));
            if (iss) begin
                chk("ctrl_we", 32'(ctrl_write_enable), 32'(wwe));
                chk("ctrl_addr", 32'(ctrl_addr), 32'(waddr));
                if (wwe) chk("ctrl_wdata", 32'(ctrl_write_data), 32'(wdata));
            end
        end
        pr_v = 1'b0;
        pw_v = 1'b0;
        if (ctrl_read_data_valid && exp_rd_q.size() > 0) begin
            it = exp_rd_q.pop_front();
            pr_v = 1'b1; pr_p = it.port; pr_d = it.data;
        end
        if (ctrl_write_done && exp_wr_q.size() > 0) begin
            it = exp_wr_q.pop_front();
            pw_v = 1'b1; pw_p = it.port;
        end
        if (reset) begin
            exp_rd_q.delete(); exp_wr_q.delete(); c_rd_q.delete();
            c_wr_cnt = 0; prio_m = 1'b0; pr_v = 1'b0; pw_v = 1'b0;
        end else if (iss) begin
            prio_m  = ~win;
            it.port = win;
            if (wwe) begin
                mem[waddr] = wdata;
                it.data    = wdata;
                exp_wr_q.push_back(it);
                c_wr_cnt++;
            end else begin
                it.data = mem[waddr];
                exp_rd_q.push_back(it);
                c_rd_q.push_back(mem[waddr]);
            end
        end
    end

    initial begin
        reset = 1'b1;
        ctrl_ready = 1'b1;
        ctrl_read_data_valid = 1'b0;
        ctrl_write_done = 1'b0;
        ctrl_read_data = '0;
        idle();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'h101] = 8'h51;
        mem[10'h202] = 8'h62;

        // Arbitration table; starts with priority on m1 (after the first m0 issue).
        vecs[0] = '{1'b1, 1'b0, 10'h101, 8'h00, 1'b0, 1'b0, 10'h202, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 10'h101, 8'h00, 1'b1, 1'b0, 10'h202, 8'h00, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 10'h101, 8'h00, 1'b1, 1'b0, 10'h202, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 10'h101, 8'h00, 1'b1, 1'b0, 10'h202, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 10'h101, 8'h00, 1'b1, 1'b0, 10'h202, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 10'h101, 8'h00, 1'b0, 1'b0, 10'h202, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 10'h101, 8'h00, 1'b1, 1'b0, 10'h202, 8'h00, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 10'h101, 8'h00, 1'b1, 1'b1, 10'h3B0, 8'h88, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 10'h3A0, 8'h77, 1'b1, 1'b1, 10'h3B0, 8'h89, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 10'h101, 8'h00, 1'b1, 1'b0, 10'h202, 8'h00, 1'b0, 1'b1};

        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");
        tick();

        // Lone m0 write is accepted at once and completes only on m0.
        set_m0(1'b1, 1'b1, 10'h0AA, 8'hA1);
        @(negedge clk);
        chk("t1_m0_ready", 32'(m0_ready), 32'(1));
        tick();
        idle();
        tick();
        @(negedge clk);
        chk("t1_m0_wdone", 32'(m0_write_done), 32'(1));
        chk("t1_m1_wdone", 32'(m1_write_done), 32'(0));
        tick();

        for (int i = 0; i < NV; i++) begin
            set_m0(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0);
            set_m1(vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            @(negedge clk);
            chk($sformatf("vec%0d_m0_ready", i), 32'(m0_ready), 32'(vecs[i].x0));
            chk($sformatf("vec%0d_m1_ready", i), 32'(m1_ready), 32'(vecs[i].x1));
            tick();
        end
        idle();
        repeat (3) tick();

        // m0 writes, then m1 reads the same address back.
        set_m0(1'b1, 1'b1, 10'h0AA, 8'h5C);
        tick();
        idle();
        set_m1(1'b1, 1'b0, 10'h0AA, 8'h00);
        tick();
        idle();
        tick();
        @(negedge clk);
        chk("t3_m1_rvalid", 32'(m1_read_data_valid), 32'(1));
        chk("t3_m1_rdata", 32'(m1_read_data), 32'(8'h5C));
        chk("t3_m0_rvalid", 32'(m0_read_data_valid), 32'(0));
        tick();
        repeat (2) tick();

        // Fill the read FIFO; further m0 reads stall while an m1 write proceeds.
        hold_rd = 1'b1;
        set_m0(1'b1, 1'b0, 10'h101, 8'h00);
        repeat (DEPTH) tick();
        set_m1(1'b1, 1'b1, 10'h3C0, 8'h99);
        @(negedge clk);
        chk("t4_m0_blocked", 32'(m0_ready), 32'(0));
        chk("t4_m1_ready", 32'(m1_ready), 32'(1));
        tick();
        set_m1(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("t4_m0_still_blocked", 32'(m0_ready), 32'(0));
        tick();
        idle();
        hold_rd = 1'b0;
        repeat (DEPTH + 3) tick();

        // Reset with two reads in flight; stray completions afterwards are ignored.
        hold_rd = 1'b1;
        set_m0(1'b1, 1'b0, 10'h101, 8'h00);
        repeat (2) tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hold_rd = 1'b0;
        @(negedge clk);
        check_outputs_zero("t5_reset");
        tick();
        stray_rd = 1'b1;
        tick();
        tick();
        stray_rd = 1'b0;
        @(negedge clk);
        chk("t5_stray_m0", 32'(m0_read_data_valid), 32'(0));
        chk("t5_stray_m1", 32'(m1_read_data_valid), 32'(0));
        tick();
        set_m0(1'b1, 1'b0, 10'h101, 8'h00);
        set_m1(1'b1, 1'b0, 10'h202, 8'h00);
        @(negedge clk);
        chk("t5_prio_m0", 32'(m0_ready), 32'(1));
        tick();
        set_m0(1'b0, 1'b0, '0, '0);
        tick();
        idle();
        tick();
        @(negedge clk);
        chk("t5_m1_rdata", 32'(m1_read_data), 32'(8'h62));
        tick();
        repeat (2) tick();

        // Same-cycle write and read completions alongside a new issue.
        hold_wr = 1'b1;
        set_m0(1'b1, 1'b1, 10'h3D0, 8'h42);
        set_m1(1'b1, 1'b0, 10'h202, 8'h00);
        tick();
        set_m0(1'b0, 1'b0, '0, '0);
        hold_wr = 1'b0;
        tick();
        set_m1(1'b0, 1'b0, '0, '0);
        set_m0(1'b1, 1'b0, 10'h101, 8'h00);
        @(negedge clk);
        chk("t6_m0_ready", 32'(m0_ready), 32'(1));
        tick();
        idle();
        @(negedge clk);
        chk("t6_m0_wdone", 32'(m0_write_done), 32'(1));
        chk("t6_m1_rvalid", 32'(m1_read_data_valid), 32'(1));
        chk("t6_m1_rdata", 32'(m1_read_data), 32'(8'h62));
        chk("t6_m0_rvalid", 32'(m0_read_data_valid), 32'(0));
        tick();
        @(negedge clk);
        chk("t6_m0_rvalid2", 32'(m0_read_data_valid), 32'(1));
        chk("t6_m0_rdata2", 32'(m0_read_data), 32'(8'h51));
        tick();
        repeat (3) tick();
        @(negedge clk);
        chk("drain_rd", 32'(exp_rd_q.size()), 32'(0));
        chk("drain_wr", 32'(exp_wr_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
